// File: rtl/fft_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_streamer
// Brief    : Reads a finished FFT frame out of BRAM and sends it as AXI4-Stream.
// Revision : 1.0 - initial release
// ============================================================================
module fft_result_streamer #(
    parameter int POINTS    = 1024,
    parameter int RAMADDR   = 9,
    parameter int WORDLEN   = 32,
    parameter int MAXSHIFTS = 8,
    parameter int RDLAT     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [MAXSHIFTS-1:0] shifts_i,
    output logic                 bram_en_o,
    output logic [RAMADDR-1:0]   bram_addr_o,
    input  logic [WORDLEN-1:0]   bram_rdata_i,
    output logic [WORDLEN-1:0]   m_axis_tdata_o,
    output logic [MAXSHIFTS-1:0] m_axis_tuser_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    output logic                 m_axis_tlast_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int c_RAMLEN     = POINTS / 2;
    localparam int c_LAST_I     = c_RAMLEN - 1;
    localparam int c_FIFO_DEPTH = RDLAT + 1;
    localparam int c_LAST_IDX_I = c_FIFO_DEPTH - 1;
    localparam int c_PTR_W      = (c_FIFO_DEPTH > 1) ? $clog2(c_FIFO_DEPTH) : 1;
    localparam int c_CNT_W      = $clog2(c_FIFO_DEPTH + 1);
    localparam int c_CRD_W      = c_CNT_W + 1;

    localparam logic [RAMADDR:0]   c_RAMLEN_P  = c_RAMLEN[RAMADDR:0];
    localparam logic [RAMADDR-1:0] c_LAST_BEAT = c_LAST_I[RAMADDR-1:0];
    localparam logic [c_PTR_W-1:0] c_LAST_IDX  = c_LAST_IDX_I[c_PTR_W-1:0];
    localparam logic [c_CRD_W-1:0] c_DEPTH_CRD = c_FIFO_DEPTH[c_CRD_W-1:0];

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]           r_state_q, w_state_d;
    logic [MAXSHIFTS-1:0] r_shifts_q, w_shifts_d;
    logic [RAMADDR:0]     r_rd_ptr_q, w_rd_ptr_d;
    logic [RAMADDR-1:0]   r_beat_cnt_q, w_beat_cnt_d;
    logic [RDLAT-1:0]     r_pipe_q, w_pipe_d;
    logic [WORDLEN-1:0]   r_fifo_mem_q [c_FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_idx_q, w_wr_idx_d;
    logic [c_PTR_W-1:0]   r_rd_idx_q, w_rd_idx_d;
    logic [c_CNT_W-1:0]   r_fifo_cnt_q, w_fifo_cnt_d;
    logic                 r_tvalid_q, w_tvalid_d;
    logic [WORDLEN-1:0]   r_tdata_q, w_tdata_d;

    logic                 w_hs;
    logic                 w_last_hs;
    logic                 w_start_acc;
    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    logic                 w_rd_issue;
    logic [c_CRD_W-1:0]   w_inflight;
    logic [c_CRD_W-1:0]   w_credit_used;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE:   if (start_i)   w_state_d = c_ST_STREAM;
            c_ST_STREAM: if (w_last_hs) w_state_d = c_ST_DONE;
            c_ST_DONE:                  w_state_d = c_ST_IDLE;
            default:                    w_state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o          = (r_state_q != c_ST_IDLE);
        done_o          = (r_state_q == c_ST_DONE);
        bram_en_o       = w_rd_issue;
        bram_addr_o     = w_rd_issue ? r_rd_ptr_q[RAMADDR-1:0] : '0;
        m_axis_tvalid_o = r_tvalid_q;
        m_axis_tdata_o  = r_tdata_q;
        m_axis_tuser_o  = r_shifts_q;
        m_axis_tlast_o  = r_tvalid_q && (r_beat_cnt_q == c_LAST_BEAT);
    end

    // ------------------------------------------------------------------
    // Handshake, FIFO movement and read credit
    // ------------------------------------------------------------------
    always_comb begin
        w_hs        = r_tvalid_q && m_axis_tready_i;
        w_last_hs   = w_hs && (r_beat_cnt_q == c_LAST_BEAT);
        w_start_acc = (r_state_q == c_ST_IDLE) && start_i;
        w_fifo_push = r_pipe_q[RDLAT-1];
        // The output register refills whenever it is empty or being drained.
        w_fifo_pop  = (r_fifo_cnt_q != '0) && (!r_tvalid_q || m_axis_tready_i);

        w_inflight = '0;
        for (int i = 0; i < RDLAT; i++) begin
            w_inflight = w_inflight + c_CRD_W'(r_pipe_q[i]);
        end

        // Occupancy after this edge if nothing new is issued; a read is only
        // launched when its data is guaranteed a FIFO slot on arrival.
        w_credit_used = c_CRD_W'(r_fifo_cnt_q) + w_inflight - c_CRD_W'(w_fifo_pop);
        w_rd_issue    = (r_state_q == c_ST_STREAM) && (r_rd_ptr_q < c_RAMLEN_P)
                        && (w_credit_used < c_DEPTH_CRD);
    end

    // ------------------------------------------------------------------
    // Read-return tracking: bit RDLAT-1 marks data arriving this cycle
    // ------------------------------------------------------------------
    generate
        if (RDLAT == 1) begin : g_pipe_single
            assign w_pipe_d = w_rd_issue;
        end else begin : g_pipe_multi
            assign w_pipe_d = {r_pipe_q[RDLAT-2:0], w_rd_issue};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_shifts_d   = r_shifts_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_beat_cnt_d = r_beat_cnt_q;

        if (w_start_acc) begin
            w_shifts_d   = shifts_i;
            w_rd_ptr_d   = '0;
            w_beat_cnt_d = '0;
        end else begin
            if (w_rd_issue) begin
                w_rd_ptr_d = r_rd_ptr_q + (RAMADDR+1)'(1);
            end
            if (w_hs) begin
                w_beat_cnt_d = r_beat_cnt_q + RAMADDR'(1);
            end
        end

        w_wr_idx_d = r_wr_idx_q;
        if (w_fifo_push) begin
            w_wr_idx_d = (r_wr_idx_q == c_LAST_IDX) ? '0 : r_wr_idx_q + c_PTR_W'(1);
        end
        w_rd_idx_d = r_rd_idx_q;
        if (w_fifo_pop) begin
            w_rd_idx_d = (r_rd_idx_q == c_LAST_IDX) ? '0 : r_rd_idx_q + c_PTR_W'(1);
        end
        w_fifo_cnt_d = r_fifo_cnt_q + c_CNT_W'(w_fifo_push) - c_CNT_W'(w_fifo_pop);

        w_tvalid_d = r_tvalid_q;
        w_tdata_d  = r_tdata_q;
        if (w_fifo_pop) begin
            w_tvalid_d = 1'b1;
            w_tdata_d  = r_fifo_mem_q[r_rd_idx_q];
        end else if (w_hs) begin
            w_tvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shifts_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_beat_cnt_q <= '0;
            r_pipe_q     <= '0;
            r_wr_idx_q   <= '0;
            r_rd_idx_q   <= '0;
            r_fifo_cnt_q <= '0;
            r_tvalid_q   <= 1'b0;
            r_tdata_q    <= '0;
        end else begin
            r_shifts_q   <= w_shifts_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_beat_cnt_q <= w_beat_cnt_d;
            r_pipe_q     <= w_pipe_d;
            r_wr_idx_q   <= w_wr_idx_d;
            r_rd_idx_q   <= w_rd_idx_d;
            r_fifo_cnt_q <= w_fifo_cnt_d;
            r_tvalid_q   <= w_tvalid_d;
            r_tdata_q    <= w_tdata_d;
        end
    end

    // FIFO storage holds data only; validity lives in the count and pointers.
    always_ff @(posedge clk_i) begin
        if (w_fifo_push) begin
            r_fifo_mem_q[r_wr_idx_q] <= bram_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Unloads a completed in-place FFT frame from the shared system memory (BRAM port B side) and transmits it as an AXI4-Stream master.
- Opposite end of the control stream the FFT core receives: the core is the stream slave, this block is the transmitter of results.
- Reads RAMLEN = POINTS/2 words of packed complex data, one word per beat, in address order.
- Tags each beat with the frame's block-floating-point shift count.

Parameters:
- POINTS, 1024, FFT size; RAMLEN = POINTS/2 words per frame.
- RAMADDR, 9, BRAM address width (log2(POINTS/2)).
- WORDLEN, 32, BRAM/stream data width (two complex 8-bit samples per word).
- MAXSHIFTS, 8, width of shift-count sideband.
- RDLAT, 1, BRAM read latency in cycles (1 or 2 supported).

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle request to stream a frame, from FFT controller
- shifts_i  in  MAXSHIFTS  total_shifts of the finished frame, sampled with start_i
- bram_en_o  out  1  BRAM read enable
- bram_addr_o  out  RAMADDR  BRAM read address
- bram_rdata_i  in  WORDLEN  BRAM read data, valid RDLAT cycles after en
- m_axis_tdata_o  out  WORDLEN  stream data
- m_axis_tuser_o  out  MAXSHIFTS  latched shift count, constant across the frame
- m_axis_tvalid_o  out  1  stream valid
- m_axis_tready_i  in  1  stream ready
- m_axis_tlast_o  out  1  high on beat RAMLEN-1 only
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: while rst_i=1 at an edge, all outputs go to 0, the FSM enters IDLE, and the FIFO and counters clear. Reset mid-frame aborts the frame: tvalid=0 the cycle after, no done pulse, and the remaining words are never sent.
- FSM states:
  - IDLE: on start_i, latch shifts_i, clear rd_ptr/beat_cnt, go to STREAM.
  - STREAM: issue reads and emit beats; when the handshake with beat_cnt=RAMLEN-1 completes, go to DONE.
  - DONE: pulse done_o for one cycle, go to IDLE.
- start_i in any state other than IDLE is ignored, with no effect on the latched shifts.
- Read issue:
  - bram_en_o=1 with bram_addr_o=rd_ptr in a STREAM cycle when rd_ptr<RAMLEN and (fifo_count + reads_in_flight) < FIFO_DEPTH.
  - FIFO_DEPTH = RDLAT+1; the credit count includes a slot freed by a same-cycle handshake.
  - rd_ptr increments per issued read and stops at RAMLEN, so no wrap.
- Read data is pushed into an internal FIFO exactly RDLAT cycles after its en cycle; the FIFO must never overflow by construction.
- Output:
  - tvalid = FIFO non-empty and tdata = FIFO head, both registered.
  - Once tvalid is asserted, tdata, tuser and tlast stay stable until tready=1.
  - A handshake (tvalid & tready) pops the FIFO and increments beat_cnt.
  - tlast = (beat_cnt == RAMLEN-1) while tvalid.
- Latency (RDLAT=1): start_i sampled at edge E0; first bram_en_o in cycle after E0; tvalid first high after edge E0+3.
- Throughput: with tready held at 1, one beat per cycle sustained, so the frame completes in RAMLEN+3 cycles from start.
- Simultaneous push and pop on the same edge: occupancy is unchanged and no beat is lost or duplicated.
- tready toggling arbitrarily must not reorder, drop or duplicate words.
- busy_o = state != IDLE; done_o asserts on the edge after the last handshake.

Test Plan:
- Preload mem[i]=0x0000_0000+i, shifts_i=8'd5, start, tready=1 -> 512 beats with tdata 0..511 consecutively, tuser=5 on all, tlast only on tdata=511, done_o one pulse at edge E0+515.
- Same frame, tready toggling 1,0,0,1 repeating -> identical data sequence and tlast position, no tdata change while tvalid&!tready, bram reads never exceed 2 ahead of pops.
- tready=0 for 20 cycles after first tvalid -> tvalid held, tdata=0 stable, at most 2 bram_en_o cycles issued, resume yields 0,1,2…
- start_i pulsed again at beat 100 with shifts_i=9 -> ignored, tuser stays 5, frame completes normally with 512 beats.
- rst_i asserted at beat 200 for one cycle -> tvalid, busy_o and done_o are 0 the next cycle; a new start yields beats starting at address 0.
- RDLAT=2 build, tready=1 -> gapless 512 beats after initial latency, correct order, FIFO never overflows (assertion).
